// File: rtl/multi_operand_adder_pipe_pkg.sv
// Shared sizing helpers for the multi-operand adder family.
// Imported by the adder tree and the pipelined top level.
package adder_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Exact width of an unsigned sum of n_in operands of width bits.
    function automatic int sum_w(input int width, input int n_in);
        return width + clog2(n_in);
    endfunction

endpackage

// File: rtl/multi_operand_adder_pipe_if.sv
// Operand/result handshake bundle for multi_operand_adder_pipe.
// The master side offers operands and consumes results; the slave side is the adder.
interface multi_operand_adder_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 3
);
    logic [N_IN*WIDTH-1:0] in_bus;
    logic                  in_mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out;
    logic                  out_ovf;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_bus, in_mode, in_valid, out_ready,
        input  in_ready, out, out_ovf, out_valid
    );

    modport slave (
        input  in_bus, in_mode, in_valid, out_ready,
        output in_ready, out, out_ovf, out_valid
    );
endinterface

// File: rtl/multi_operand_adder_pipe_adder_tree.sv
// Combinational sum of N_IN packed WIDTH-bit operands, exact at sum_w(WIDTH, N_IN) bits.
module adder_tree
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 3
) (
    input  logic [N_IN*WIDTH-1:0]            in_bus,
    output logic [sum_w(WIDTH, N_IN)-1:0]    sum
);
    localparam int SUM_W = sum_w(WIDTH, N_IN);

    // NOTE: blocking '=' is correct here: the loop chains partial sums within one evaluation.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = sum + SUM_W'(in_bus[k*WIDTH +: WIDTH]);
        end
    end
endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Two-stage pipelined multi-operand adder with load/accumulate and valid/ready on both sides.
// Define ADDER_SAT_EN to clamp results at 2^WIDTH-1 instead of wrapping.
module multi_operand_adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    multi_operand_adder_pipe_if.slave  bus
);
    localparam int                SUM_W   = sum_w(WIDTH, N_IN);
    localparam int                FULL_W  = SUM_W + 1;
    localparam logic [FULL_W-1:0] MAX_VAL = FULL_W'({WIDTH{1'b1}});

    logic [SUM_W-1:0]  tree_sum;
    logic [SUM_W-1:0]  s1_sum;
    logic              s1_mode;
    logic              s1_valid;
    logic [WIDTH-1:0]  acc;
    logic [FULL_W-1:0] full;
    logic [WIDTH-1:0]  fit_val;
    logic              ovf;
    logic              s1_en;
    logic              s2_en;

    adder_tree #(.WIDTH(WIDTH), .N_IN(N_IN)) u_tree (
        .in_bus (bus.in_bus),
        .sum    (tree_sum)
    );

    // S2 may drain in the same edge S1 refills, so no bubble at full throughput.
    assign s2_en        = !bus.out_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en && !rst;

    always_comb begin
        full = s1_mode ? FULL_W'(acc) + FULL_W'(s1_sum) : FULL_W'(s1_sum);
        ovf  = full > MAX_VAL;
`ifdef ADDER_SAT_EN
        fit_val = ovf ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
        fit_val = full[WIDTH-1:0];
`endif
    end

    // NOTE: every register, datapath included, is reset so a mid-run reset leaves no stale data visible.
    // NOTE: sequential state uses '<=' so S1 and S2 both see pre-edge values when they advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum        <= '0;
            s1_mode       <= 1'b0;
            s1_valid      <= 1'b0;
            acc           <= '0;
            bus.out       <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sum  <= tree_sum;
                    s1_mode <= bus.in_mode;
                end
            end
            if (s2_en) begin
                bus.out_valid <= s1_valid;
                // acc advances only as a transaction enters S2, keeping it equal to the last result.
                if (s1_valid) begin
                    bus.out     <= fit_val;
                    bus.out_ovf <= ovf;
                    acc         <= fit_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed bench for multi_operand_adder_pipe (WIDTH=8, N_IN=3) with a scoreboard queue.
// Expected results follow the wrap or clamp rule depending on ADDER_SAT_EN.
module tb_multi_operand_adder_pipe;
    localparam int WIDTH = 8;
    localparam int N_IN  = 3;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    multi_operand_adder_pipe_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();

    multi_operand_adder_pipe #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;
    int   model_acc = 0;
    logic last_in_ready;
    logic last_in_fire;
    int   send_ticks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: computes the result a transaction must produce, in acceptance order.
    task automatic model_push(input int a, input int b, input int c, input logic mode);
        int   full;
        exp_t e;
        full = mode ? model_acc + a + b + c : a + b + c;
        e.ovf = (full > 255);
`ifdef ADDER_SAT_EN
        e.out = e.ovf ? 8'd255 : full[7:0];
`else
        e.out = full[7:0];
`endif
        model_acc = int'(e.out);
        sb.push_back(e);
    endtask

    // Called at a negedge with inputs already driven; samples mid-low-phase, then advances one cycle.
    task automatic tick();
        exp_t e;
        #1;
        last_in_ready = bus.in_ready;
        last_in_fire  = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out", 32'(bus.out), 32'(e.out));
                check("ovf", 32'(bus.out_ovf), 32'(e.ovf));
                pops++;
            end
        end
        if (last_in_fire)
            model_push(int'(bus.in_bus[7:0]), int'(bus.in_bus[15:8]), int'(bus.in_bus[23:16]), bus.in_mode);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic m);
        bus.in_bus   = {c, b, a};
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        last_in_fire = 1'b0;
        send_ticks   = 0;
        while (!last_in_fire && send_ticks < 20) begin
            tick();
            send_ticks++;
        end
        if (!last_in_fire) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int pops_before;
        rst           = 1'b1;
        bus.in_bus    = '0;
        bus.in_mode   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Single transaction: two-cycle latency.
        send(8'd10, 8'd11, 8'd12, 1'b0);
        check("lat_s1_only", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_out_33", 32'(bus.out), 32'd33);
        drain();

        // Back-to-back loads, one acceptance per cycle.
        send(8'd10, 8'd11, 8'd12, 1'b0);
        check("b2b_ticks0", 32'(send_ticks), 32'd1);
        send(8'd20, 8'd21, 8'd22, 1'b0);
        check("b2b_ticks1", 32'(send_ticks), 32'd1);
        send(8'd30, 8'd31, 8'd32, 1'b0);
        check("b2b_ticks2", 32'(send_ticks), 32'd1);
        drain();

        // Overflow on load.
        send(8'd200, 8'd100, 8'd50, 1'b0);
        drain();

        // Accumulate sequence, back to back.
        send(8'd1,   8'd2,   8'd3, 1'b0);
        send(8'd10,  8'd10,  8'd10, 1'b1);
        send(8'd100, 8'd100, 8'd0, 1'b1);
        send(8'd10,  8'd10,  8'd0, 1'b1);
        send(8'd5,   8'd0,   8'd0, 1'b1);
        drain();

        // Backpressure: results held, S1 fills once, then input stalls.
        pops_before   = pops;
        bus.out_ready = 1'b0;
        send(8'd10, 8'd11, 8'd12, 1'b0);
        send(8'd20, 8'd21, 8'd22, 1'b0);
        bus.in_bus   = {8'd32, 8'd31, 8'd30};
        bus.in_mode  = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready_low", 32'(last_in_ready), 32'd0);
            check("bp_out_hold", 32'(bus.out), 32'd33);
            check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        send(8'd30, 8'd31, 8'd32, 1'b0);
        drain();
        check("bp_count", 32'(pops - pops_before), 32'd3);

        // Reset with two transactions in flight.
        send(8'd1, 8'd2, 8'd3, 1'b0);
        send(8'd4, 8'd5, 8'd6, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out", 32'(bus.out), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        model_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_quiet0", 32'(bus.out_valid), 32'd0);
        tick();
        check("post_rst_quiet1", 32'(bus.out_valid), 32'd0);
        send(8'd1, 8'd1, 8'd1, 1'b1);
        tick();
        check("post_rst_acc_out", 32'(bus.out), 32'd3);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multi_operand_adder_pipe.md
# multi_operand_adder_pipe

Pipelined, parametrised multi-operand unsigned adder. It sums N_IN operands of WIDTH bits per transaction and can either load or accumulate into a running total. Valid/ready handshakes on both sides. It is the general-purpose successor to the fixed 3-input, 8-bit combinational adder and serves as the arithmetic stage in datapaths that need backpressure.

## Interface
- WIDTH, 8: operand and result width in bits (≥ 2).
- N_IN, 3: operands per transaction (2..8).
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_BUS  in  N_IN*WIDTH  packed operands; operand k = IN_BUS[k*WIDTH +: WIDTH].
- IN_MODE  in  1  0 = load (result = sum), 1 = accumulate (result = acc + sum).
- IN_VALID  in  1  input transaction offered.
- IN_READY  out  1  input accepted when IN_VALID & IN_READY at a rising edge.
- OUT  out  WIDTH  result.
- OUT_OVF  out  1  result exceeded 2^WIDTH-1 before wrap or clamp.
- OUT_VALID  out  1  OUT/OUT_OVF valid.
- OUT_READY  in  1  result consumed when OUT_VALID & OUT_READY at a rising edge.

## Operation
- SUM_W = WIDTH + clog2(N_IN). The operand sum is exact at SUM_W bits.
- Stage 1 (S1) registers s1_sum (SUM_W), s1_mode and s1_valid on acceptance.
- Stage 2 (S2) computes full = s1_mode ? acc + s1_sum : s1_sum at SUM_W+1 bits.
  - Registers OUT = fit(full) and OUT_OVF = (full > 2^WIDTH-1).
  - Sets acc <= fit(full) and sets OUT_VALID.
- fit() is wrap or clamp per Configuration. acc is always WIDTH bits and always equals the last OUT.
- acc updates only when a transaction enters S2. It does not update when the transaction is accepted at the input.
- Mode 0 restarts the accumulation. Mode 1 with acc = 0 after reset equals load.
- Flow control:
  - s2_en = !OUT_VALID | OUT_READY
  - s1_en = !s1_valid | s2_en
  - IN_READY = s1_en & !RST
- IN_READY depends combinationally on OUT_READY; this path is permitted.
- No transaction is dropped or duplicated under any OUT_READY pattern. Results leave in acceptance order.

## Timing
- Reset values: OUT = 0, OUT_OVF = 0, OUT_VALID = 0, s1_valid = 0, acc = 0. IN_READY = 0 while RST is high and 1 in the first cycle after release.
- Latency: a transaction accepted at edge n is in S1 after edge n and presents OUT_VALID = 1 after edge n+1, i.e. 2 cycles.
- Throughput: 1 transaction/cycle while OUT_READY = 1.
- OUT_VALID=1 & OUT_READY=0: OUT, OUT_OVF and acc hold stable. S1 still fills once, then IN_READY = 0.
- Simultaneous S2 output consumption and S1 advance in the same edge is required, giving full throughput with no bubble.
- Back-to-back mode-1 transactions use the acc value written by the immediately preceding transaction at the preceding edge.
- Reset mid-operation: all in-flight transactions are discarded and acc is cleared immediately (asynchronously). There is no partial output after release.

## Configuration
- ADDER_SAT_EN undefined: fit(full) = full mod 2^WIDTH (wrap). OUT_OVF = 1 on wrap.
- ADDER_SAT_EN defined: fit(full) = min(full, 2^WIDTH-1) (clamp). OUT_OVF = 1 on clamp. acc holds the clamped value.

## Structure
- Package adder_pkg holds a clog2 constant function and the sum-width helper SUM_W(WIDTH, N_IN), for reuse by other adders.
- One sub-module, adder_tree: combinational N_IN-operand sum from IN_BUS to SUM_W bits, parametrised by WIDTH and N_IN.
- The top level holds the S1/S2 registers, acc, fit logic and handshake.

## Test plan
All cases use WIDTH = 8, N_IN = 3.
- Reset, then {10,11,12} mode 0 with OUT_READY = 1 → OUT = 33, OUT_OVF = 0, OUT_VALID two cycles after acceptance.
- Back-to-back {10,11,12}, {20,21,22}, {30,31,32} mode 0 → 33, 63, 93 on consecutive cycles, IN_READY constantly 1.
- {200,100,50} mode 0 → wrap build: OUT = 94, OVF = 1; ADDER_SAT_EN build: OUT = 255, OVF = 1.
- Accumulate sequence, expected OUT per transaction:
  - {1,2,3} m0 → 6
  - {10,10,10} m1 → 36
  - {100,100,0} m1 → 236
  - {10,10,0} m1 → wrap: 0 (OVF 1); sat: 255 (OVF 1)
  - {5,0,0} m1 → wrap: 5; sat: 255 (OVF 1)
- Backpressure: hold OUT_READY = 0 while offering the three back-to-back transactions.
  - OUT stays 33 and IN_READY falls after the second acceptance.
  - On release the outputs are 33, 63, 93 with no loss or duplicate.
- Reset mid-operation: assert RST with two transactions in flight → OUT_VALID = 0 and OUT = 0 immediately. After release, {1,1,1} mode 1 → OUT = 3.
